// File: rtl/spi_subordinate_controller.sv
// SPI subordinate: oversamples the SPI pins in the system clock domain, deserializes MOSI onto
// a valid/ready RX port and serializes a one-entry TX buffer onto MISO.
module spi_subordinate_controller #(
  parameter bit         CPOL         = 1'b0,
  parameter bit         CPHA         = 1'b0,
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_cs,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_overrun,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic       o_busy
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e     r_state;
  state_e     w_state_next;

  logic       r_sclk_meta, r_sclk_s, r_sclk_d;
  logic       r_mosi_meta, r_mosi_s;
  logic       r_cs_meta, r_cs_s;

  logic [6:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_overrun;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_buf;
  logic       r_tx_full;
  logic       r_tx_underrun;
  logic       r_miso;

  logic       w_cs_fall, w_cs_rise;
  logic       w_rise, w_fall, w_lead, w_trail;
  logic       w_in_xfer, w_sample, w_shift, w_load;

  // Two-flop synchronizers plus one delayed copy of sclk for edge detection.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sclk_meta <= CPOL;
      r_sclk_s    <= CPOL;
      r_sclk_d    <= CPOL;
      r_mosi_meta <= 1'b0;
      r_mosi_s    <= 1'b0;
      r_cs_meta   <= 1'b1;
      r_cs_s      <= 1'b1;
    end else begin
      r_sclk_meta <= i_sclk;
      r_sclk_s    <= r_sclk_meta;
      r_sclk_d    <= r_sclk_s;
      r_mosi_meta <= i_mosi;
      r_mosi_s    <= r_mosi_meta;
      r_cs_meta   <= i_cs;
      r_cs_s      <= r_cs_meta;
    end
  end

  // Transfer state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state follows synchronized cs; flags mark the cs_s falling and rising cycles.
  always_comb begin
    w_state_next = r_state;
    w_cs_fall    = 1'b0;
    w_cs_rise    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_cs_s) begin
          w_state_next = StActive;
          w_cs_fall    = 1'b1;
        end
      end
      StActive: begin
        if (r_cs_s) begin
          w_state_next = StIdle;
          w_cs_rise    = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // SCLK edge roles for the configured mode; edges count only inside an active transfer.
  always_comb begin
    w_rise    = r_sclk_s && !r_sclk_d;
    w_fall    = !r_sclk_s && r_sclk_d;
    w_lead    = CPOL ? w_fall : w_rise;
    w_trail   = CPOL ? w_rise : w_fall;
    w_in_xfer = (r_state == StActive) && !r_cs_s;
    w_sample  = w_in_xfer && (CPHA ? w_trail : w_lead);
    w_shift   = w_in_xfer && (CPHA ? w_lead : w_trail);
    // With CPHA=0 the only shift edge seen at bit_cnt==0 is the one after bit 7 was sampled.
    w_load    = (w_shift && (r_bit_cnt == 3'd0)) || (w_cs_fall && !CPHA);
  end

  // RX deserializer and handshake.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_overrun <= 1'b0;
      if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_cs_fall || w_cs_rise) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (w_sample) begin
        r_rx_shift <= {r_rx_shift[5:0], r_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data    <= {r_rx_shift, r_mosi_s};
          r_rx_valid   <= 1'b1;
          r_rx_overrun <= r_rx_valid && !i_rx_ready;
        end
      end
    end
  end

  // TX buffer, shifter and registered MISO.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_shift    <= '0;
      r_tx_buf      <= '0;
      r_tx_full     <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_miso        <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      r_miso        <= r_tx_shift[7];
      if (w_cs_rise) begin
        r_tx_shift <= '0;
      end else if (w_load) begin
        r_tx_shift    <= r_tx_full ? r_tx_buf : TX_IDLE_BYTE;
        r_tx_underrun <= !r_tx_full;
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      // A write coinciding with a load into an empty buffer is kept for the next load.
      if (w_load && r_tx_full) begin
        r_tx_full <= 1'b0;
      end else if (i_tx_valid && !r_tx_full) begin
        r_tx_full <= 1'b1;
        r_tx_buf  <= i_tx_data;
      end
    end
  end

  assign o_miso        = r_miso;
  assign o_miso_oe     = (r_state == StActive);
  assign o_busy        = (r_state == StActive);
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_overrun  = r_rx_overrun;
  assign o_tx_ready    = !r_tx_full;
  assign o_tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_subordinate_controller.sv
// Bench for spi_subordinate_controller: one instance per SPI mode, driven by a behavioural
// SPI manager and checked against a transaction-level model of the TX buffer and RX port.
module tb_spi_subordinate_controller;

  localparam int H = 5;  // SCLK half period in system clocks

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk [4];
  logic       mosi [4];
  logic       cs [4];
  logic       rx_ready [4];
  logic       tx_valid [4];
  logic [7:0] tx_data [4];
  logic       miso [4];
  logic       miso_oe [4];
  logic [7:0] rx_data [4];
  logic       rx_valid [4];
  logic       rx_overrun [4];
  logic       tx_ready [4];
  logic       tx_underrun [4];
  logic       busy [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per mode
  logic       mdl_full [4];
  logic [7:0] mdl_buf [4];
  logic [7:0] mdl_cur [4];
  logic       exp_rxv [4];
  logic [7:0] exp_rxd [4];
  int         exp_und [4];
  int         exp_ovr [4];
  int         und_cnt [4];
  int         ovr_cnt [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_subordinate_controller #(
      .CPOL        (g >= 2),
      .CPHA        ((g % 2) == 1),
      .TX_IDLE_BYTE(8'hFF)
    ) u_dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_sclk       (sclk[g]),
      .i_mosi       (mosi[g]),
      .i_cs         (cs[g]),
      .o_miso       (miso[g]),
      .o_miso_oe    (miso_oe[g]),
      .o_rx_data    (rx_data[g]),
      .o_rx_valid   (rx_valid[g]),
      .i_rx_ready   (rx_ready[g]),
      .o_rx_overrun (rx_overrun[g]),
      .i_tx_data    (tx_data[g]),
      .i_tx_valid   (tx_valid[g]),
      .o_tx_ready   (tx_ready[g]),
      .o_tx_underrun(tx_underrun[g]),
      .o_busy       (busy[g])
    );
  end

  // Pulse counters on the DUT status outputs
  initial begin
    for (int i = 0; i < 4; i++) begin
      und_cnt[i] = 0;
      ovr_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tx_underrun[i] === 1'b1) und_cnt[i] <= und_cnt[i] + 1;
      if (rx_overrun[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      mdl_full[i] = 1'b0;
      mdl_buf[i]  = 8'h00;
      mdl_cur[i]  = 8'h00;
      exp_rxv[i]  = 1'b0;
      exp_rxd[i]  = 8'h00;
    end
  endtask

  // A load takes the buffered byte, or the idle byte with an underrun
  task automatic m_load(input int m);
    if (mdl_full[m]) begin
      mdl_cur[m]  = mdl_buf[m];
      mdl_full[m] = 1'b0;
    end else begin
      mdl_cur[m] = 8'hFF;
      exp_und[m]++;
    end
  endtask

  task automatic tx_write(input int m, input logic [7:0] b);
    int t = 0;
    while (tx_ready[m] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (tx_ready[m] !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_write_wait mode%0d: tx_ready=%b required 1", m, tx_ready[m]);
    end else begin
      tx_valid[m] = 1'b1;
      tx_data[m]  = b;
      @(negedge clk);
      tx_valid[m] = 1'b0;
      mdl_full[m] = 1'b1;
      mdl_buf[m]  = b;
      n_checks++;
      if (tx_ready[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL tx_ready_after_write mode%0d: got %b required 0", m, tx_ready[m]);
      end
    end
  endtask

  // Assert cs; optionally offer a TX byte in exactly the cs_s falling cycle.
  task automatic cs_assert(input int m, input bit inject, input logic [7:0] b);
    cs[m] = 1'b0;
    wait_clk(2);
    if (inject) begin
      tx_valid[m] = 1'b1;
      tx_data[m]  = b;
      wait_clk(1);
      tx_valid[m] = 1'b0;
    end
    wait_clk(6);
    if ((m % 2) == 0) m_load(m);
    if (inject) begin
      mdl_full[m] = 1'b1;
      mdl_buf[m]  = b;
    end
    n_checks++;
    if (busy[m] !== 1'b1 || miso_oe[m] !== 1'b1) begin
      n_fail++;
      $display("FAIL cs_assert_busy mode%0d: busy=%b miso_oe=%b required 1 1", m, busy[m],
               miso_oe[m]);
    end
    n_checks++;
    if (tx_ready[m] !== ~mdl_full[m]) begin
      n_fail++;
      $display("FAIL cs_assert_tx_ready mode%0d: got %b required %b", m, tx_ready[m],
               ~mdl_full[m]);
    end
  endtask

  // Behavioural SPI manager: nbits MSB first, returns the bits read from MISO.
  task automatic spi_byte(input int m, input logic [7:0] b, input int nbits,
                          output logic [7:0] got);
    logic cpol;
    logic cpha;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    got  = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = b[i];
        wait_clk(H);
        got[i]  = miso[m];
        sclk[m] = ~cpol;
        wait_clk(H);
        sclk[m] = cpol;
      end else begin
        wait_clk(H);
        sclk[m] = ~cpol;
        mosi[m] = b[i];
        wait_clk(H);
        got[i]  = miso[m];
        sclk[m] = cpol;
      end
    end
    wait_clk(H);
  endtask

  task automatic do_byte(input int m, input logic [7:0] b);
    logic [7:0] got;
    logic [7:0] exp_m;
    if ((m % 2) == 1) m_load(m);
    exp_m = mdl_cur[m];
    spi_byte(m, b, 8, got);
    if (exp_rxv[m]) exp_ovr[m]++;
    exp_rxv[m] = 1'b1;
    exp_rxd[m] = b;
    if ((m % 2) == 0) m_load(m);
    n_checks++;
    if (got !== exp_m) begin
      n_fail++;
      $display("FAIL miso_byte mode%0d: manager read %h required %h", m, got, exp_m);
    end
    n_checks++;
    if (rx_valid[m] !== 1'b1 || rx_data[m] !== exp_rxd[m]) begin
      n_fail++;
      $display("FAIL rx_byte mode%0d: rx_valid=%b rx_data=%h required 1 %h", m, rx_valid[m],
               rx_data[m], exp_rxd[m]);
    end
  endtask

  task automatic rx_pop(input int m);
    rx_ready[m] = 1'b1;
    wait_clk(1);
    rx_ready[m] = 1'b0;
    exp_rxv[m]  = 1'b0;
    wait_clk(1);
    n_checks++;
    if (rx_valid[m] !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_pop mode%0d: rx_valid=%b required 0", m, rx_valid[m]);
    end
  endtask

  task automatic cs_release(input int m);
    cs[m] = 1'b1;
    wait_clk(3);
    n_checks++;
    if (busy[m] !== 1'b0 || miso_oe[m] !== 1'b0) begin
      n_fail++;
      $display("FAIL cs_release_busy mode%0d: busy=%b miso_oe=%b required 0 0", m, busy[m],
               miso_oe[m]);
    end
    wait_clk(3);
    n_checks++;
    if (und_cnt[m] != exp_und[m] || ovr_cnt[m] != exp_ovr[m]) begin
      n_fail++;
      $display("FAIL pulse_counts mode%0d: underruns=%0d overruns=%0d required %0d %0d", m,
               und_cnt[m], ovr_cnt[m], exp_und[m], exp_ovr[m]);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int m = 0; m < 4; m++) begin
      n_checks++;
      if (tx_ready[m] !== 1'b1 || miso[m] !== 1'b0 || miso_oe[m] !== 1'b0 ||
          busy[m] !== 1'b0 || rx_valid[m] !== 1'b0 || rx_data[m] !== 8'h00 ||
          rx_overrun[m] !== 1'b0 || tx_underrun[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s mode%0d: tx_ready=%b miso=%b oe=%b busy=%b rxv=%b rxd=%h ovr=%b und=%b required 1 0 0 0 0 00 0 0",
                 nm, m, tx_ready[m], miso[m], miso_oe[m], busy[m], rx_valid[m], rx_data[m],
                 rx_overrun[m], tx_underrun[m]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sclk[m]     = (m >= 2);
      mosi[m]     = 1'b0;
      cs[m]       = 1'b1;
      rx_ready[m] = 1'b0;
      tx_valid[m] = 1'b0;
      tx_data[m]  = 8'h00;
      exp_und[m]  = 0;
      exp_ovr[m]  = 0;
    end
    m_reset();
    wait_clk(3);
    check_reset_outputs("reset_asserted");
    rst_n = 1'b1;
    wait_clk(5);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_mode0();
    tx_write(0, 8'hA5);
    cs_assert(0, 1'b0, 8'h00);
    do_byte(0, 8'h3C);
    cs_release(0);
    rx_pop(0);
  endtask

  task automatic test_modes123();
    for (int m = 1; m < 4; m++) begin
      tx_write(m, 8'h5A);
      cs_assert(m, 1'b0, 8'h00);
      do_byte(m, 8'hC3);
      cs_release(m);
      rx_pop(m);
    end
  endtask

  task automatic test_back_to_back();
    int und0;
    int ovr0;
    und0 = und_cnt[1];
    ovr0 = ovr_cnt[1];
    cs_assert(1, 1'b0, 8'h00);
    do_byte(1, 8'h01);
    do_byte(1, 8'h02);
    cs_release(1);
    n_checks++;
    if (und_cnt[1] - und0 != 2 || ovr_cnt[1] - ovr0 != 1 || rx_data[1] !== 8'h02) begin
      n_fail++;
      $display("FAIL back_to_back: underruns=%0d overruns=%0d rx_data=%h required 2 1 02",
               und_cnt[1] - und0, ovr_cnt[1] - ovr0, rx_data[1]);
    end
    rx_pop(1);
  endtask

  task automatic test_cs_abort();
    logic [7:0] got;
    cs_assert(0, 1'b0, 8'h00);
    spi_byte(0, 8'hFF, 5, got);
    cs_release(0);
    n_checks++;
    if (rx_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cs_abort_rx_valid: got %b required 0", rx_valid[0]);
    end
    cs_assert(0, 1'b0, 8'h00);
    do_byte(0, 8'h81);
    cs_release(0);
    rx_pop(0);
  endtask

  task automatic test_tx_inject();
    cs_assert(0, 1'b1, 8'h77);
    do_byte(0, 8'h12);
    rx_pop(0);
    do_byte(0, 8'h34);
    cs_release(0);
    rx_pop(0);
  endtask

  task automatic test_async_reset();
    logic [7:0] got;
    cs_assert(0, 1'b0, 8'h00);
    tx_write(0, 8'h3E);
    spi_byte(0, 8'h55, 3, got);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid_byte");
    @(negedge clk);
    cs[0]   = 1'b1;
    sclk[0] = 1'b0;
    mosi[0] = 1'b0;
    m_reset();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    cs_assert(0, 1'b0, 8'h00);
    do_byte(0, 8'h96);
    cs_release(0);
    rx_pop(0);
  endtask

  task automatic test_random();
    int m;
    int nb;
    for (int it = 0; it < 12; it++) begin
      m  = int'($urandom_range(0, 3));
      nb = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1 && !mdl_full[m]) tx_write(m, 8'($urandom));
      cs_assert(m, 1'b0, 8'h00);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (!mdl_full[m]) begin
            tx_write(m, 8'($urandom));
          end else begin
            n_checks++;
            if (tx_ready[m] !== 1'b0) begin
              n_fail++;
              $display("FAIL random_tx_ready_full mode%0d: got %b required 0", m, tx_ready[m]);
            end
          end
        end
        do_byte(m, 8'($urandom));
        if ($urandom_range(0, 1) == 1) rx_pop(m);
      end
      cs_release(m);
      if (exp_rxv[m]) rx_pop(m);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes123();
    test_back_to_back();
    test_cs_abort();
    test_tx_inject();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_subordinate_controller.md
Name: spi_subordinate_controller

Overview:
Synthesizable SPI subordinate that connects directly to the sclk/mosi/miso/cs pins driven by the rvx_ocelot SPI manager. It oversamples all SPI pins in the system clock domain. It deserializes MOSI into bytes presented on a valid/ready RX port, and serializes bytes from a one-entry TX buffer onto MISO. It serves as the real-hardware counterpart of the bench subordinate models and is the endpoint for SPI manager HAL tests on FPGA.

Parameters:
CPOL, 0, SCLK idle level; 0 means idle low, 1 means idle high.
CPHA, 0, 0: sample on leading edge and shift on trailing edge; 1: shift on leading edge and sample on trailing edge.
TX_IDLE_BYTE, 8'hFF, byte shifted out when the TX buffer is empty at a load event.

Ports:
clock  input  1  system clock; all logic on posedge.
reset_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock from the manager; asynchronous to clock.
mosi  input  1  SPI data from the manager; asynchronous.
cs  input  1  chip select, active low; asynchronous.
miso  output  1  serial data to the manager; valid only while miso_oe=1.
miso_oe  output  1  MISO drive enable; the top level builds the tristate.
rx_data  output  8  last received byte.
rx_valid  output  1  rx_data holds an unconsumed byte.
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
rx_overrun  output  1  one-cycle pulse when a byte completes while rx_valid=1 and rx_ready=0.
tx_data  input  8  byte to transmit.
tx_valid  input  1  tx_data is offered.
tx_ready  output  1  TX buffer is empty.
tx_underrun  output  1  one-cycle pulse when a load event finds the TX buffer empty.
busy  output  1  synchronized cs is asserted.

Behaviour:
- Reset (asynchronous, active low): all outputs are 0 except tx_ready=1; miso=0; synchronizers load their idle values (sclk=CPOL, cs=1); shifters, bit counter and TX buffer are cleared.
- Synchronization: sclk, mosi and cs each pass through 2 flip-flops. A further register on synchronized sclk (sclk_d) provides edge detection.
  - rise = sclk_s && !sclk_d; fall = !sclk_s && sclk_d.
  - leading edge = rise when CPOL=0, fall when CPOL=1; trailing edge is the opposite.
- Edge roles: sample_edge = leading when CPHA=0, trailing when CPHA=1; shift_edge is the other edge.
- Timing requirement: SCLK high and low times are each ≥4 clock periods. Faster SCLK is unsupported and need not be detected.
- States:
  - IDLE: cs_s=1. Entered on reset or whenever cs_s rises, from any state.
  - ACTIVE: cs_s=0. Entered when cs_s falls; this cycle sets bit_cnt=0.
  - Events are ignored in IDLE.
- Load event: the TX shifter takes the TX buffer (buffer becomes empty, tx_ready=1) or, if the buffer is empty, TX_IDLE_BYTE with a tx_underrun pulse. A load event occurs:
  - CPHA=0: in the cs_s falling cycle, and on every shift_edge that follows the sample of bit 7.
  - CPHA=1: on each shift_edge with bit_cnt=0.
- Non-load shift_edge: the TX shifter shifts left by 1.
- MISO output: miso = shifter[7], MSB first, registered. It changes 3–4 clocks after the pin edge.
- Sample edge: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt increments and wraps 7→0.
  - When bit_cnt==7: rx_data <= {rx_shift[6:0], mosi_s} and rx_valid=1.
  - If rx_valid was already set and not being consumed in that same cycle, the old byte is overwritten and rx_overrun pulses.
  - Completion and consumption in the same cycle leave rx_valid=1 with the new byte, with no overrun.
- RX handshake: rx_valid clears on rx_valid && rx_ready. rx_data is stable while rx_valid=1, except on overrun.
- TX handshake: tx_valid && tx_ready writes tx_data into the buffer, and tx_ready drops the next cycle. A write in the same cycle as a load event into an empty buffer does not bypass: the shifter takes TX_IDLE_BYTE and the buffer keeps the new byte for the following load.
- miso_oe = busy = !cs_s (registered).
- cs_s rising mid-byte: bit_cnt=0, partial RX is discarded with no rx_valid and no overrun, and the TX shifter is discarded. The TX buffer is untouched. With CPHA=0, a byte loaded on the final trailing edge is consumed even if cs rises next.
- Asynchronous reset mid-transfer behaves as a full reset; the next transfer starts cleanly at the next cs_s fall.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), SCLK period 10 clocks: preload tx 8'hA5, manager sends 8'h3C. Required: miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid=1; tx_ready=1 after cs_s falls.
- Modes 1, 2 and 3, each sending 8'hC3 with tx 8'h5A: sampling occurs on the correct edge. Required: rx_data=8'hC3 and manager reads 8'h5A in every mode.
- Two back-to-back bytes 8'h01, 8'h02 with rx_ready held 0 and no TX preload. Required: rx_overrun pulses once, rx_data=8'h02, tx_underrun pulses twice, miso all 1s.
- cs deasserted after 5 bits of 8'hFF. Required: rx_valid stays 0, busy=0 and miso_oe=0 within 3 clocks. The next full transfer of 8'h81 yields rx_data=8'h81.
- tx_valid asserted in the same cycle as a CPHA=0 load with buffer empty, tx_data=8'h77. Required: the current byte is 8'hFF with tx_underrun=1; the next byte sent is 8'h77.
- reset_n pulsed low mid-byte, asynchronously between clock edges. Required: outputs clear immediately to their reset values (tx_ready=1, miso_oe=0); a subsequent transfer of 8'h96 is received correctly.
